uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Parametrised UART transmit serializer. Accepts one data word per valid/ready handshake and frames it as start bit, WORD_SIZE data bits (LSB first), optional parity bit, then 1 or 2 stop bits. Each bit is held for CLKS_PER_BIT clocks by an internal bit-period counter. Sits between the TX FIFO / packet formatter and the board TX pin; it replaces the fixed 8N1 shift register and its external baud sequencing.

Parameters:
WORD_SIZE, 8, data bits per frame; legal range 5..9
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2
CNT_W, $clog2(CLKS_PER_BIT), bit-period counter width (derived, not overridden)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_data  input  WORD_SIZE  word to transmit; sampled on accept
tx_valid  input  1  upstream has a word
tx_ready  output  1  block can accept a word (high only in IDLE)
parity_sel  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none); sampled on accept
two_stop  input  1  0 = one stop bit, 1 = two stop bits; sampled on accept
tx_serial  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk (clock port clk, reset port reset).
- Reset values: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_serial=1, tx_ready=1. Accept happens on the edge where tx_valid && tx_ready. At accept, latch tx_data, parity_sel and two_stop, then go to START.
- tx_serial is registered. The start bit (0) appears the cycle after accept. The same cycle, tx_ready drops and tx_busy rises.
- Each bit is held exactly CLKS_PER_BIT cycles. The bit counter counts 0..CLKS_PER_BIT-1 and advances the bit on terminal count.
- START -> DATA after 1 bit period.
- DATA shifts out bit 0 first. After WORD_SIZE bits it goes to PARITY if parity is enabled, else to STOP.
- Parity bit: even = XOR of the latched data bits; odd = inverted XOR.
- STOP drives 1 for 1 or 2 bit periods. tx_done pulses in the final cycle of the final stop bit. The next cycle is IDLE with tx_ready=1 and tx_busy=0.
- Frame length F = 1 + WORD_SIZE + P + S bits, where P is 0/1 and S is 1/2. tx_ready is low for exactly F*CLKS_PER_BIT cycles.
- The minimum gap between frames is 1 idle cycle (accept in the first IDLE cycle).
- tx_valid while busy is ignored and consumes nothing. Changes to tx_data, parity_sel or two_stop mid-frame do not affect the current frame.
- parity_sel=11 behaves exactly as 00.
- Reset mid-frame: the next cycle has tx_serial=1 and the FSM is in IDLE. The partial frame is abandoned, no tx_done, and no word is retained.
- Reset wins over a simultaneous accept.

Decomposition:
- Shared package uart_pkg holds: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), FSM state encoding, and the IDLE_LEVEL=1'b1 constant. The future RX block uses the same package.
- One sub-module: uart_bit_timer (counter with a start/clear input and a terminal-count pulse output, parameter CLKS_PER_BIT). It is reused by the RX side.

Test Plan:
1. WORD_SIZE=8, CLKS_PER_BIT=4, 8N1, send 0xA5 -> tx_serial = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); tx_ready low 40 cycles; tx_done high on cycle 40.
2. Even parity, 0x07 -> parity bit 1, frame 11 bits/44 cycles. Odd parity, 0x07 -> parity bit 0. parity_sel=11 -> 10-bit frame, same as 8N1.
3. two_stop=1, 0x00, no parity -> start plus 8 zeros, then 8 cycles high before tx_done; ready low 44 cycles.
4. Hold tx_valid high with 0x11 then 0x22 queued -> two frames; exactly 1 idle high cycle between the last stop cycle and the next start bit. tx_data changed to 0xFF mid-frame -> first frame still 0x11.
5. Assert reset in the middle of data bit 3 -> tx_serial=1, tx_ready=1, tx_busy=0 next cycle; no tx_done. The next accepted 0x3C transmits correctly.
6. WORD_SIZE=5, CLKS_PER_BIT=2, 5E2, send 5'b10110 -> bits 0,0,1,1,0,1,1,1,1 (parity 1), each 2 cycles, 18 cycles total.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, FSM state encoding and line idle level.
// Used by both the TX serializer and the RX side.
package uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tc on the
// last count of each period. clear holds the count at zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    assign tc = enable && (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, WORD_SIZE data bits LSB first, optional
// parity, then one or two stop bits, each held CLKS_PER_BIT clocks.
//
// state  | meaning
// IDLE   | line high, tx_ready high, waiting for tx_valid
// START  | driving the start bit (0)
// DATA   | shifting out data bits, LSB first
// PARITY | driving the latched parity bit
// STOP   | driving 1 for one or two bit periods; tx_done on the final cycle
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [1:0]           parity_sel,
    input  logic                 two_stop,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    uart_state_e          state;
    uart_state_e          state_next;
    logic [WORD_SIZE-1:0] shreg;
    logic [WORD_SIZE-1:0] shreg_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 two_stop_q;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 bit_tc;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;
    logic                 serial_next;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .tc     (bit_tc)
    );

    assign tx_ready  = (state == IDLE);
    assign tx_busy   = (state != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign last_data = (bit_cnt == BIT_W'(WORD_SIZE - 1));
    assign last_stop = (stop_cnt == two_stop_q);
    assign tx_done   = (state == STOP) && bit_tc && last_stop;

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_next = START;
                    shreg_next = tx_data;
                end
            end
            START: begin
                if (bit_tc) state_next = DATA;
            end
            DATA: begin
                if (bit_tc) begin
                    shreg_next = shreg >> 1;
                    if (last_data) state_next = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_tc) state_next = STOP;
            end
            STOP: begin
                if (bit_tc && last_stop) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The line is registered, so its next level follows the next state.
    always_comb begin
        serial_next = IDLE_LEVEL;
        case (state_next)
            START:   serial_next = ~IDLE_LEVEL;
            DATA:    serial_next = shreg_next[0];
            PARITY:  serial_next = par_bit_q;
            default: serial_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            two_stop_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_serial  <= IDLE_LEVEL;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            tx_serial <= serial_next;
            if (accept) begin
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                two_stop_q <= two_stop;
                par_en_q   <= (parity_sel == PAR_EVEN) || (parity_sel == PAR_ODD);
                par_bit_q  <= (^tx_data) ^ (parity_sel == PAR_ODD);
            end else begin
                if (state == DATA && bit_tc) bit_cnt <= bit_cnt + BIT_W'(1);
                if (state == STOP && bit_tc) stop_cnt <= ~stop_cnt;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: an 8-bit/4-clock instance and a 5-bit/2-clock
// instance, checked cycle by cycle against a per-cycle expected-line scoreboard.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_8, valid_8, two_8;
    logic [7:0] data_8;
    logic [1:0] sel_8;
    logic       ready_8, serial_8, busy_8, done_8;

    logic       rst_5, valid_5, two_5;
    logic [4:0] data_5;
    logic [1:0] sel_5;
    logic       ready_5, serial_5, busy_5, done_5;

    uart_tx_serializer #(.WORD_SIZE(8), .CLKS_PER_BIT(4)) dut8 (
        .clk        (clk),
        .reset      (rst_8),
        .tx_data    (data_8),
        .tx_valid   (valid_8),
        .tx_ready   (ready_8),
        .parity_sel (sel_8),
        .two_stop   (two_8),
        .tx_serial  (serial_8),
        .tx_busy    (busy_8),
        .tx_done    (done_8)
    );

    uart_tx_serializer #(.WORD_SIZE(5), .CLKS_PER_BIT(2)) dut5 (
        .clk        (clk),
        .reset      (rst_5),
        .tx_data    (data_5),
        .tx_valid   (valid_5),
        .tx_ready   (ready_5),
        .parity_sel (sel_5),
        .two_stop   (two_5),
        .tx_serial  (serial_5),
        .tx_busy    (busy_5),
        .tx_done    (done_5)
    );

    typedef struct packed {
        logic serial;
        logic ready;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   use5     = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [8:0] data, input logic [1:0] sel, input logic two);
        logic bits[$];
        logic p;
        int   width;
        int   cpb;
        exp_t e;
        width = use5 ? 5 : 8;
        cpb   = use5 ? 2 : 4;
        p     = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < width; i++) begin
            bits.push_back(data[i]);
            p = p ^ data[i];
        end
        if (sel == 2'b01) bits.push_back(p);
        if (sel == 2'b10) bits.push_back(~p);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < cpb; k++) begin
                e.serial = bits[b];
                e.ready  = 1'b0;
                e.busy   = 1'b1;
                e.done   = (b == bits.size() - 1) && (k == cpb - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e.serial = 1'b1;
        e.ready  = 1'b1;
        e.busy   = 1'b0;
        e.done   = 1'b0;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic drain(input string name, input int n);
        exp_t e;
        logic s, r, b, d;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scoreboard empty at cycle %0d: got no entry, required one", name, i);
                return;
            end
            e = sb.pop_front();
            s = use5 ? serial_5 : serial_8;
            r = use5 ? ready_5  : ready_8;
            b = use5 ? busy_5   : busy_8;
            d = use5 ? done_5   : done_8;
            n_checks++;
            if (s !== e.serial) begin
                n_fail++;
                $display("FAIL %s tx_serial cycle %0d: got %b required %b", name, i, s, e.serial);
            end
            n_checks++;
            if (r !== e.ready) begin
                n_fail++;
                $display("FAIL %s tx_ready cycle %0d: got %b required %b", name, i, r, e.ready);
            end
            n_checks++;
            if (b !== e.busy) begin
                n_fail++;
                $display("FAIL %s tx_busy cycle %0d: got %b required %b", name, i, b, e.busy);
            end
            n_checks++;
            if (d !== e.done) begin
                n_fail++;
                $display("FAIL %s tx_done cycle %0d: got %b required %b", name, i, d, e.done);
            end
            tick();
        end
    endtask

    task automatic drain_all(input string name);
        drain(name, sb.size());
    endtask

    task automatic start_frame(input logic [8:0] data, input logic [1:0] sel, input logic two);
        if (use5) begin
            data_5  = data[4:0];
            sel_5   = sel;
            two_5   = two;
            valid_5 = 1'b1;
        end else begin
            data_8  = data[7:0];
            sel_8   = sel;
            two_8   = two;
            valid_8 = 1'b1;
        end
        push_frame(data, sel, two);
        tick();
        valid_5 = 1'b0;
        valid_8 = 1'b0;
    endtask

    task automatic test_reset;
        rst_8 = 1'b1;
        rst_5 = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({serial_8, ready_8, busy_8, done_8} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_8 {serial,ready,busy,done}: got %b required 1100",
                     {serial_8, ready_8, busy_8, done_8});
        end
        n_checks++;
        if ({serial_5, ready_5, busy_5, done_5} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_5 {serial,ready,busy,done}: got %b required 1100",
                     {serial_5, ready_5, busy_5, done_5});
        end
        rst_8 = 1'b0;
        rst_5 = 1'b0;
        use5 = 1'b0;
        push_idle(2);
        drain_all("reset_idle_8");
    endtask

    task automatic test_8n1;
        use5 = 1'b0;
        start_frame(9'h0A5, 2'b00, 1'b0);
        push_idle(1);
        drain_all("8n1_a5");
    endtask

    task automatic test_parity;
        use5 = 1'b0;
        start_frame(9'h007, 2'b01, 1'b0);
        push_idle(1);
        drain_all("even_07");
        start_frame(9'h007, 2'b10, 1'b0);
        push_idle(1);
        drain_all("odd_07");
        start_frame(9'h007, 2'b11, 1'b0);
        push_idle(1);
        drain_all("sel11_07");
    endtask

    task automatic test_two_stop;
        use5 = 1'b0;
        start_frame(9'h000, 2'b00, 1'b1);
        push_idle(1);
        drain_all("two_stop_00");
    endtask

    task automatic test_back_to_back;
        use5    = 1'b0;
        data_8  = 8'h11;
        sel_8   = 2'b00;
        two_8   = 1'b0;
        valid_8 = 1'b1;
        push_frame(9'h011, 2'b00, 1'b0);
        push_idle(1);
        push_frame(9'h022, 2'b00, 1'b0);
        push_idle(1);
        tick();
        drain("b2b_first", 10);
        data_8 = 8'hFF;
        sel_8  = 2'b01;
        two_8  = 1'b1;
        drain("b2b_first", 20);
        data_8 = 8'h22;
        sel_8  = 2'b00;
        two_8  = 1'b0;
        drain("b2b_first", 10);
        drain("b2b_gap", 1);
        valid_8 = 1'b0;
        drain_all("b2b_second");
    endtask

    task automatic test_reset_mid_frame;
        use5 = 1'b0;
        start_frame(9'h096, 2'b01, 1'b1);
        drain("rst_pre", 17);
        rst_8 = 1'b1;
        tick();
        rst_8 = 1'b0;
        sb.delete();
        push_idle(6);
        drain_all("rst_post");
        data_8  = 8'h55;
        sel_8   = 2'b00;
        two_8   = 1'b0;
        valid_8 = 1'b1;
        rst_8   = 1'b1;
        tick();
        rst_8   = 1'b0;
        valid_8 = 1'b0;
        push_idle(4);
        drain_all("rst_wins");
        start_frame(9'h03C, 2'b00, 1'b0);
        push_idle(1);
        drain_all("after_rst_3c");
    endtask

    task automatic test_5e2;
        use5 = 1'b1;
        start_frame(9'b0_0001_0110, 2'b01, 1'b1);
        push_idle(1);
        drain_all("5e2_16");
        use5 = 1'b0;
    endtask

    initial begin
        rst_8   = 1'b1;
        valid_8 = 1'b0;
        data_8  = '0;
        sel_8   = 2'b00;
        two_8   = 1'b0;
        rst_5   = 1'b1;
        valid_5 = 1'b0;
        data_5  = '0;
        sel_5   = 2'b00;
        two_5   = 1'b0;

        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_5e2();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
